memory_arbiter: RTL and testbench
=================================

Name: memory_arbiter

Overview:
- Shares the single-port 64 KiB byte memory (memory_block, 16-bit address, 8-bit data) between two requesters.
  - Port 0 is the 6502 core.
  - Port 1 is the debug/program loader.
- Sequences every access: one command per grant, then waits out the memory read latency and returns read data with a valid strobe.
- Sits directly between the requesters and the memory instance; it is the only driver of the memory's ena/wea/addra/dina.

Parameters:
- READ_LATENCY, 1, cycles from memory command to douta valid (1 = no output register, 2 = output register enabled); legal range 1..4
- FIXED_PRIORITY, 0, 0 = round-robin between ports; 1 = port 0 always wins ties

Ports:
- clk_sys  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- p0_req  in  1  port 0 access request, held until p0_gnt
- p0_we  in  1  port 0 write enable (1 = write, 0 = read), valid with p0_req
- p0_addr  in  16  port 0 byte address
- p0_wdata  in  8  port 0 write data
- p0_gnt  out  1  one-cycle pulse: port 0 command issued this cycle
- p0_rvalid  out  1  one-cycle pulse: p0_rdata valid
- p0_rdata  out  8  port 0 read data
- p1_req / p1_we / p1_addr / p1_wdata / p1_gnt / p1_rvalid / p1_rdata  same as port 0, for port 1
- mem_en  out  1  to memory ena
- mem_we  out  1  to memory wea
- mem_addr  out  16  to memory addra
- mem_wdata  out  8  to memory dina
- mem_rdata  in  8  from memory douta

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - State IDLE, all outputs 0.
  - Round-robin pointer set so that port 0 wins the first tie.
  - Reset mid-access abandons it; no rvalid is produced for that access.
- States:
  - IDLE: evaluate p0_req/p1_req. If none, stay. Else pick winner, go ISSUE.
  - ISSUE (1 cycle):
    - mem_en=1, mem_we/addr/wdata registered from the winner; winner's gnt=1.
    - Write: go IDLE.
    - Read: go WAIT with counter = READ_LATENCY.
  - WAIT: decrement counter each cycle. When counter reaches 1, capture mem_rdata into the winner's rdata register; go IDLE.
- Read timing, relative to ISSUE cycle G:
  - Memory output is valid in cycle G+READ_LATENCY.
  - Winner's rvalid=1 in cycle G+READ_LATENCY+1; rdata holds that value until the next read on the same port.
- Throughput:
  - Writes: 1 access per 2 cycles.
  - Reads: 1 per READ_LATENCY+2 cycles.
  - The next grant can issue no earlier than 1 cycle after the current access's WAIT state ends.
- Arbitration:
  - Only one requesting port: it wins.
  - Both requesting, FIXED_PRIORITY=0: the port not granted last wins; the pointer updates on every grant.
  - Both requesting, FIXED_PRIORITY=1: port 0 wins.
- Requester rules:
  - req, we, addr and wdata are sampled only in IDLE and must be stable until gnt.
  - Dropping req before gnt withdraws the request; no access occurs.
  - Holding req after gnt is a new request.
- mem_en is high only in ISSUE; mem_we is 0 whenever mem_en is 0.
- The full address range 0x0000..0xFFFF is reachable. No wrap logic; the address passes through unchanged.
- gnt and rvalid for the two ports are never high in the same cycle for different ports.

Decomposition:
- Package memory_arbiter_pkg:
  - arb_state_t enum (IDLE, ISSUE, WAIT)
  - port index constants PORT_CPU=0, PORT_LDR=1
  - latency counter width derived from the max READ_LATENCY (3 bits)
- Sub-module rr_select_2: combinational winner select from two requests, last-grant pointer and FIXED_PRIORITY. Returns the winner index and an any-request flag.

Test Plan:
- Port 1 writes 0xA5 to 0x0200, then port 0 reads 0x0200 (READ_LATENCY=1) -> p1_gnt pulses 1 cycle; p0_rvalid high exactly 2 cycles after the p0_gnt cycle with p0_rdata=0xA5; p1_rvalid never pulses.
- Both ports request reads in the same cycle, held for 4 grants, FIXED_PRIORITY=0 -> grant order 0,1,0,1; no grant while WAIT is active.
- Same stimulus with FIXED_PRIORITY=1 -> port 0 granted every time; port 1 starved while p0_req is held.
- READ_LATENCY=2, port 0 reads 0xFFFF after writing 0x3C there -> mem_addr=0xFFFF; p0_rvalid 3 cycles after p0_gnt with p0_rdata=0x3C.
- Assert reset_n=0 during WAIT of a port-1 read, release after 3 cycles -> all outputs 0 immediately; no p1_rvalid afterwards; the first tied request goes to port 0.
- Port 0 raises req for 1 cycle while port 1's read is in WAIT, then drops it -> no p0_gnt; mem_en stays 0 after the port-1 ISSUE cycle.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Imported by the arbiter top and its winner-select helper.
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    localparam int MAX_READ_LATENCY = 4;
    localparam int LAT_W = $clog2(MAX_READ_LATENCY + 1);

    typedef logic [LAT_W-1:0] lat_cnt_t;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } mem_cmd_t;

endpackage

// File: rtl/memory_arbiter_rr_select.sv
// Two-way winner select: round-robin on the last grant, or
// fixed priority to the CPU port when FIXED_PRIORITY is set.
module rr_select_2
    import memory_arbiter_pkg::*;
#(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       winner,
    output logic       any_req
);

    always_comb begin
        any_req = |req;
        winner  = PORT_CPU;
        unique case (req)
            2'b11: begin
                if (FIXED_PRIORITY != 0) winner = PORT_CPU;
                else                     winner = ~last_gnt;
            end
            2'b10:   winner = PORT_LDR;
            default: winner = PORT_CPU;
        endcase
    end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one single-port byte memory between the 6502 core (port 0)
// and the debug loader (port 1): one command per grant, then read wait.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int READ_LATENCY   = 1,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [15:0] p0_addr,
    input  logic [7:0]  p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [7:0]  p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [15:0] p1_addr,
    input  logic [7:0]  p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [7:0]  p1_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    arb_state_t state;
    arb_state_t state_next;
    lat_cnt_t   cnt;
    lat_cnt_t   cnt_next;
    mem_cmd_t   cmd_q;
    mem_cmd_t   cmd_sel;
    logic       owner;
    logic       last_gnt;
    logic       sel;
    logic       any_req;
    logic       capture;
    logic       issue;
    logic [1:0] rvalid_q;
    logic [7:0] rdata0_q;
    logic [7:0] rdata1_q;

    rr_select_2 #(
        .FIXED_PRIORITY(FIXED_PRIORITY)
    ) u_sel (
        .req      ({p1_req, p0_req}),
        .last_gnt (last_gnt),
        .winner   (sel),
        .any_req  (any_req)
    );

    always_comb begin
        if (sel == PORT_LDR) cmd_sel = '{p1_we, p1_addr, p1_wdata};
        else                 cmd_sel = '{p0_we, p0_addr, p0_wdata};
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) state_next = ISSUE;
            end
            ISSUE: begin
                if (cmd_q.we) begin
                    state_next = IDLE;
                end else begin
                    state_next = WAIT;
                    cnt_next   = lat_cnt_t'(READ_LATENCY);
                end
            end
            WAIT: begin
                // count 1 marks the cycle douta is valid
                if (cnt == lat_cnt_t'(1)) begin
                    capture    = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - lat_cnt_t'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            cmd_q    <= '0;
            owner    <= PORT_CPU;
            last_gnt <= PORT_LDR;
            rvalid_q <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            rvalid_q <= '0;
            if (state == IDLE && any_req) begin
                cmd_q    <= cmd_sel;
                owner    <= sel;
                last_gnt <= sel;
            end
            if (capture) begin
                if (owner == PORT_LDR) begin
                    rvalid_q[1] <= 1'b1;
                    rdata1_q    <= mem_rdata;
                end else begin
                    rvalid_q[0] <= 1'b1;
                    rdata0_q    <= mem_rdata;
                end
            end
        end
    end

    assign issue     = (state == ISSUE);
    assign mem_en    = issue;
    assign mem_we    = issue & cmd_q.we;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;

    assign p0_gnt    = issue & (owner == PORT_CPU);
    assign p1_gnt    = issue & (owner == PORT_LDR);
    assign p0_rvalid = rvalid_q[0];
    assign p1_rvalid = rvalid_q[1];
    assign p0_rdata  = rdata0_q;
    assign p1_rdata  = rdata1_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: four configurations, each with its own
// memory model, checked against a transaction-level reference.
module tb_memory_arbiter;

    localparam int NI = 4;
    localparam int LATS [NI] = '{1, 1, 2, 4};
    localparam int FPS  [NI] = '{0, 1, 0, 0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [NI-1:0] rst_n;
    logic [1:0]    req   [NI];
    logic [1:0]    we    [NI];
    logic [15:0]   addr  [NI][2];
    logic [7:0]    wdata [NI][2];

    logic        gnt0 [NI];
    logic        gnt1 [NI];
    logic        rv0  [NI];
    logic        rv1  [NI];
    logic [7:0]  rd0  [NI];
    logic [7:0]  rd1  [NI];
    logic        men  [NI];
    logic        mwe  [NI];
    logic [15:0] maddr[NI];
    logic [7:0]  mwd  [NI];
    logic [7:0]  mrd  [NI];

    logic [7:0] ref_mem [NI][65536];
    int         last_ref [NI];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [7:0] mem  [65536];
        logic [7:0] pipe [4];

        memory_arbiter #(
            .READ_LATENCY   (LATS[g]),
            .FIXED_PRIORITY (FPS[g])
        ) u_dut (
            .clk_sys   (clk),
            .reset_n   (rst_n[g]),
            .p0_req    (req[g][0]),
            .p0_we     (we[g][0]),
            .p0_addr   (addr[g][0]),
            .p0_wdata  (wdata[g][0]),
            .p0_gnt    (gnt0[g]),
            .p0_rvalid (rv0[g]),
            .p0_rdata  (rd0[g]),
            .p1_req    (req[g][1]),
            .p1_we     (we[g][1]),
            .p1_addr   (addr[g][1]),
            .p1_wdata  (wdata[g][1]),
            .p1_gnt    (gnt1[g]),
            .p1_rvalid (rv1[g]),
            .p1_rdata  (rd1[g]),
            .mem_en    (men[g]),
            .mem_we    (mwe[g]),
            .mem_addr  (maddr[g]),
            .mem_wdata (mwd[g]),
            .mem_rdata (mrd[g])
        );

        initial for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        always @(posedge clk) begin
            if (men[g]) begin
                if (mwe[g]) mem[maddr[g]] <= mwd[g];
                pipe[0] <= mem[maddr[g]];
            end
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end
        assign mrd[g] = pipe[LATS[g]-1];

        always @(negedge clk) begin
            if (rst_n[g]) begin
                chk("gnt_exclusive", {31'd0, gnt0[g] & gnt1[g]}, 0);
                chk("rvalid_exclusive", {31'd0, rv0[g] & rv1[g]}, 0);
                chk("mem_en_vs_gnt", {31'd0, men[g]}, {31'd0, gnt0[g] | gnt1[g]});
                chk("mem_we_gated", {31'd0, mwe[g] & ~men[g]}, 0);
            end
        end
    end

    function automatic logic f_gnt(int k, int p);
        return (p == 1) ? gnt1[k] : gnt0[k];
    endfunction

    function automatic logic f_rv(int k, int p);
        return (p == 1) ? rv1[k] : rv0[k];
    endfunction

    function automatic logic [7:0] f_rd(int k, int p);
        return (p == 1) ? rd1[k] : rd0[k];
    endfunction

    // winner of the next grant, from the arbitration rules
    function automatic int ref_pick(int k, bit r0, bit r1);
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
        if (FPS[k] != 0) return 0;
        return 1 - last_ref[k];
    endfunction

    task automatic step(int k, bit r0, bit r1, bit w0, bit w1,
                        logic [15:0] a0, logic [15:0] a1,
                        logic [7:0] d0, logic [7:0] d1);
        bit         pend [2];
        bit         wrv  [2];
        int         gcyc [2];
        logic [7:0] erd  [2];
        int         nxt;
        int         prev_end;
        @(negedge clk);
        req[k] = {r1, r0};
        we[k]  = {w1, w0};
        addr[k][0]  = a0;
        addr[k][1]  = a1;
        wdata[k][0] = d0;
        wdata[k][1] = d1;
        pend = '{r0, r1};
        wrv  = '{1'b0, 1'b0};
        nxt  = ref_pick(k, r0, r1);
        prev_end = -1;
        for (int n = 0; n < 40 && (pend[0] || pend[1] || wrv[0] || wrv[1]); n++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (f_gnt(k, p)) begin
                    chk("gnt_unrequested", {31'd0, pend[p]}, 1);
                    if (pend[p]) begin
                        chk("gnt_port", p, nxt);
                        if (prev_end >= 0) chk("gnt_spacing", cyc, prev_end);
                        chk("mem_addr", {16'd0, maddr[k]}, {16'd0, addr[k][p]});
                        chk("mem_we", {31'd0, mwe[k]}, {31'd0, we[k][p]});
                        if (we[k][p]) chk("mem_wdata", {24'd0, mwd[k]}, {24'd0, wdata[k][p]});
                        pend[p] = 1'b0;
                        req[k][p] = 1'b0;
                        last_ref[k] = p;
                        if (we[k][p]) begin
                            ref_mem[k][addr[k][p]] = wdata[k][p];
                            prev_end = cyc + 2;
                        end else begin
                            wrv[p]  = 1'b1;
                            gcyc[p] = cyc;
                            erd[p]  = ref_mem[k][addr[k][p]];
                            prev_end = cyc + LATS[k] + 2;
                        end
                        nxt = 1 - p;
                    end
                end
                if (f_rv(k, p)) begin
                    chk("rvalid_unexpected", {31'd0, wrv[p]}, 1);
                    if (wrv[p]) begin
                        chk("rvalid_latency", cyc - gcyc[p], LATS[k] + 1);
                        chk("rdata", {24'd0, f_rd(k, p)}, {24'd0, erd[p]});
                        wrv[p] = 1'b0;
                    end
                end
            end
        end
        chk("step_done", {28'd0, pend[0], pend[1], wrv[0], wrv[1]}, 0);
        req[k] = 2'b00;
    endtask

    task automatic hold_test(int k, logic [15:0] a);
        int grants;
        int last_g;
        int exp_p;
        @(negedge clk);
        req[k] = 2'b11;
        we[k]  = 2'b00;
        addr[k][0] = a;
        addr[k][1] = a;
        grants = 0;
        last_g = -1;
        for (int n = 0; n < 60 && grants < 4; n++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (f_rv(k, p))
                    chk("hold_rdata", {24'd0, f_rd(k, p)}, {24'd0, ref_mem[k][a]});
                if (f_gnt(k, p)) begin
                    exp_p = (FPS[k] != 0) ? 0 : 1 - last_ref[k];
                    chk("hold_order", p, exp_p);
                    if (last_g >= 0) chk("hold_spacing", cyc - last_g, LATS[k] + 2);
                    last_g = cyc;
                    last_ref[k] = p;
                    grants++;
                    if (grants == 4) req[k] = 2'b00;
                end
            end
        end
        chk("hold_grants", grants, 4);
        req[k] = 2'b00;
        repeat (LATS[k] + 3) @(negedge clk);
    endtask

    initial begin
        int  gc;
        bit  seen;
        bit  r0;
        bit  r1;
        logic [15:0] ra0;
        logic [15:0] ra1;

        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 65536; i++) ref_mem[k][i] = 8'h00;
            last_ref[k] = 1;
            req[k] = 2'b00;
            we[k]  = 2'b00;
            addr[k][0] = '0;
            addr[k][1] = '0;
            wdata[k][0] = '0;
            wdata[k][1] = '0;
        end
        rst_n = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("reset_outputs",
                {8'd0, gnt0[k], gnt1[k], rv0[k], rv1[k], men[k], mwe[k], 2'd0, rd0[k], rd1[k]}, 0);
            chk("reset_mem_bus", {8'd0, maddr[k], mwd[k]}, 0);
        end
        rst_n = '1;

        // loader writes, CPU reads back with latency 1
        step(0, 0, 1, 0, 1, 16'h0000, 16'h0200, 8'h00, 8'hA5);
        step(0, 1, 0, 0, 0, 16'h0200, 16'h0000, 8'h00, 8'h00);
        chk("tp1_rdata", {24'd0, rd0[0]}, 32'hA5);

        hold_test(0, 16'h0200);
        step(1, 0, 1, 0, 1, 16'h0000, 16'h0040, 8'h00, 8'h5A);
        hold_test(1, 16'h0040);

        // top address with latency 2
        step(2, 1, 0, 1, 0, 16'hFFFF, 16'h0000, 8'h3C, 8'h00);
        step(2, 1, 0, 0, 0, 16'hFFFF, 16'h0000, 8'h00, 8'h00);
        chk("tp4_rdata", {24'd0, rd0[2]}, 32'h3C);

        // withdrawn request during a port-1 read wait
        @(negedge clk);
        req[2] = 2'b10;
        we[2]  = 2'b00;
        addr[2][1] = 16'hFFFF;
        gc = -1;
        for (int n = 0; n < 20 && gc < 0; n++) begin
            @(negedge clk);
            if (gnt1[2]) gc = cyc;
        end
        chk("wd_p1_granted", {31'd0, gc >= 0}, 1);
        req[2] = 2'b00;
        last_ref[2] = 1;
        @(negedge clk);
        req[2][0] = 1'b1;
        addr[2][0] = 16'h0123;
        @(negedge clk);
        req[2][0] = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("wd_no_p0_gnt", {31'd0, gnt0[2]}, 0);
            chk("wd_mem_en_low", {31'd0, men[2]}, 0);
        end

        // reset in the middle of a port-1 read wait
        @(negedge clk);
        req[3] = 2'b10;
        we[3]  = 2'b00;
        addr[3][1] = 16'h1234;
        gc = -1;
        for (int n = 0; n < 20 && gc < 0; n++) begin
            @(negedge clk);
            if (gnt1[3]) gc = cyc;
        end
        chk("rst_p1_granted", {31'd0, gc >= 0}, 1);
        req[3] = 2'b00;
        @(negedge clk);
        rst_n[3] = 1'b0;
        #1;
        chk("rst_mid_outputs",
            {8'd0, gnt0[3], gnt1[3], rv0[3], rv1[3], men[3], mwe[3], 2'd0, rd0[3], rd1[3]}, 0);
        chk("rst_mid_bus", {8'd0, maddr[3], mwd[3]}, 0);
        repeat (3) @(negedge clk);
        rst_n[3] = 1'b1;
        last_ref[3] = 1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rv1[3]) seen = 1'b1;
        end
        chk("rst_no_p1_rvalid", {31'd0, seen}, 0);
        step(3, 1, 1, 0, 0, 16'h0010, 16'h0020, 8'h00, 8'h00);

        // random traffic on every configuration
        for (int k = 0; k < NI; k++) begin
            for (int t = 0; t < 40; t++) begin
                r0 = 1'($urandom_range(0, 1));
                r1 = 1'($urandom_range(0, 1));
                if (!r0 && !r1) r0 = 1'b1;
                ra0 = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'h0300 + 16'($urandom_range(0, 7));
                ra1 = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'h0300 + 16'($urandom_range(0, 7));
                step(k, r0, r1,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     ra0, ra1,
                     8'($urandom), 8'($urandom));
            end
        end

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
